// File: rtl/float_rec_nr.sv
`default_nettype none
// ============================================================================
// Module   : float_rec_nr
// Purpose  : IEEE-754 reciprocal (Y = 1/X) by Newton-Raphson on one shared
//            multiplier. Define FLOAT_REC_STATUS_EN to add the flags port.
// Revision : 1.0
// ============================================================================
module float_rec_nr #(
    parameter int DATA_WIDTH = 32,
    parameter int EXP_W      = 8,
    parameter int ITERS      = 3,
    parameter int FRAC_W     = 30
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] X,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Y
`ifdef FLOAT_REC_STATUS_EN
    ,
    output logic [2:0]            flags
`endif
);

    localparam int MAN_W = DATA_WIDTH - EXP_W - 1;
    localparam int VAL_W = FRAC_W + 2;
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;

    // Seed x0 = 24/17 - 8/17*m approximates 1/m for m in [1,2) (|1-m*x0| <= 1/17)
    localparam logic [VAL_W-1:0] c_k1 = VAL_W'(((FRAC_W+6)'(24) << FRAC_W) / (FRAC_W+6)'(17));
    localparam logic [VAL_W-1:0] c_k2 = VAL_W'(((FRAC_W+6)'(8) << FRAC_W) / (FRAC_W+6)'(17));
    localparam logic [VAL_W-1:0] c_two      = VAL_W'(2) << FRAC_W;
    localparam logic [EXP_W+1:0] c_two_bias = (EXP_W+2)'(2 * BIAS);
    localparam logic [2:0]       c_last     = 3'(ITERS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEED  = 3'd1,
        S_MUL_A = 3'd2,
        S_MUL_B = 3'd3,
        S_NORM  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_sign;
    logic [EXP_W-1:0]      r_exp;
    logic [MAN_W-1:0]      r_man;
    logic [VAL_W-1:0]      r_x;
    logic [VAL_W-1:0]      r_t;
    logic [2:0]            r_iter;
    logic [DATA_WIDTH-1:0] r_y;

    logic                  w_exp_zero;
    logic                  w_exp_ones;
    logic                  w_man_zero;
    logic                  w_special;
    logic [VAL_W-1:0]      w_m;
    logic [VAL_W-1:0]      w_mul_a;
    logic [VAL_W-1:0]      w_mul_b;
    logic [2*VAL_W-1:0]    w_prod;
    logic [VAL_W-1:0]      w_prod_q;
    logic                  w_unused;
    logic [EXP_W+1:0]      w_res_exp;
    logic                  w_uflow;
    logic [MAN_W-1:0]      w_norm_man;
    logic [DATA_WIDTH-1:0] w_special_y;
    logic [2:0]            w_special_flags;

    assign w_exp_zero = (r_exp == '0);
    assign w_exp_ones = &r_exp;
    assign w_man_zero = (r_man == '0);
    assign w_special  = w_exp_zero | w_exp_ones;
    assign w_m        = {1'b0, 1'b1, r_man, {(FRAC_W-MAN_W){1'b0}}};

    // Single multiplier, operands steered by state
    always_comb begin
        w_mul_a = w_m;
        w_mul_b = r_x;
        case (r_state)
            S_SEED:  begin w_mul_a = c_k2; w_mul_b = w_m;          end
            S_MUL_A: begin w_mul_a = w_m;  w_mul_b = r_x;          end
            S_MUL_B: begin w_mul_a = r_x;  w_mul_b = c_two - r_t;  end
            default: ;
        endcase
    end

    assign w_prod   = {{VAL_W{1'b0}}, w_mul_a} * {{VAL_W{1'b0}}, w_mul_b};
    assign w_prod_q = w_prod[FRAC_W +: VAL_W];
    assign w_unused = ^{w_prod[FRAC_W-1:0], w_prod[2*VAL_W-1:FRAC_W+VAL_W]};

    // x ~ 1/m lies in (0.5,1); taking bits below the first fraction bit is x<<1
    assign w_res_exp  = c_two_bias - {2'b00, r_exp} - {{(EXP_W+1){1'b0}}, ~w_man_zero};
    assign w_uflow    = w_res_exp[EXP_W+1] | (w_res_exp == '0);
    assign w_norm_man = w_man_zero ? '0 : r_x[FRAC_W-2 -: MAN_W];

    always_comb begin
        w_special_y     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        w_special_flags = 3'b010;
        if (w_exp_zero) begin
            w_special_y     = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_special_flags = 3'b001;
        end else if (w_man_zero) begin
            w_special_y     = {r_sign, {(DATA_WIDTH-1){1'b0}}};
            w_special_flags = 3'b000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_SEED;
            S_SEED:  w_state_nxt = w_special ? S_DONE : S_MUL_A;
            S_MUL_A: w_state_nxt = S_MUL_B;
            S_MUL_B: w_state_nxt = (r_iter == c_last) ? S_NORM : S_MUL_A;
            S_NORM:  w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign <= 1'b0;
            r_exp  <= '0;
            r_man  <= '0;
            r_x    <= '0;
            r_t    <= '0;
            r_iter <= '0;
            r_y    <= '0;
        end else begin
            case (r_state)
                S_IDLE:  if (in_valid) {r_sign, r_exp, r_man} <= X;
                S_SEED: begin
                    r_iter <= '0;
                    if (w_special) r_y <= w_special_y;
                    else           r_x <= c_k1 - w_prod_q;
                end
                S_MUL_A: r_t <= w_prod_q;
                S_MUL_B: begin
                    r_x    <= w_prod_q;
                    r_iter <= r_iter + 3'd1;
                end
                S_NORM: begin
                    if (w_uflow) r_y <= {r_sign, {(DATA_WIDTH-1){1'b0}}};
                    else         r_y <= {r_sign, w_res_exp[EXP_W-1:0], w_norm_man};
                end
                default: ;
            endcase
        end
    end

`ifdef FLOAT_REC_STATUS_EN
    logic [2:0] r_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 3'b000;
        end else if (r_state == S_SEED && w_special) begin
            r_flags <= w_special_flags;
        end else if (r_state == S_NORM) begin
            r_flags <= {w_uflow, 2'b00};
        end
    end

    assign flags = r_flags;
`else
    logic w_unused_flags;
    assign w_unused_flags = ^w_special_flags;
`endif

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign Y         = r_y;

endmodule
`default_nettype wire

// File: tb/tb_float_rec_nr.sv
`default_nettype none
// ============================================================================
// Module   : tb_float_rec_nr
// Purpose  : Directed self-checking bench for float_rec_nr (default params).
// Revision : 1.0
// ============================================================================
module tb_float_rec_nr;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] X;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Y;
`ifdef FLOAT_REC_STATUS_EN
    logic [2:0]  flags;
`endif

    int checks   = 0;
    int failures = 0;

    float_rec_nr dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y)
`ifdef FLOAT_REC_STATUS_EN
        ,
        .flags     (flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                            input int tol);
        logic [31:0] diff;
        diff = (obs > exp) ? obs - exp : exp - obs;
        checks++;
        assert (diff <= 32'(tol)) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (+/-%0d)", tag, obs, exp, tol);
        end
    endtask

    // Latency counts the accepting edge as cycle 1; out_ready assumed high.
    task automatic run_op(input logic [31:0] x, input logic [31:0] exp_y, input int tol,
                          input int exp_lat, input logic [2:0] exp_flags, input string tag);
        int lat;
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        X        = x;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 60) begin
            step();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (tol == 0) chk({tag, "_y"}, Y, exp_y);
        else          chk_near({tag, "_y"}, Y, exp_y, tol);
`ifdef FLOAT_REC_STATUS_EN
        chk({tag, "_flags"}, {29'd0, flags}, {29'd0, exp_flags});
`else
        if (exp_flags === 3'bxxx) $display("unreachable");
`endif
        step();
        chk({tag, "_release"}, {30'd0, out_valid, in_ready}, 32'h1);
    endtask

    initial begin
        int seen;
        int guard;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        X         = 32'h0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_y", Y, 32'h0);
`ifdef FLOAT_REC_STATUS_EN
        chk("rst_flags", {29'd0, flags}, 32'h0);
`endif
        repeat (2) step();
        rst_n = 1'b1;
        step();

        run_op(32'h40000000, 32'h3F000000, 0, 9, 3'b000, "two");
        run_op(32'hC0800000, 32'hBE800000, 0, 9, 3'b000, "neg_four");
        run_op(32'h40400000, 32'h3EAAAAAB, 2, 9, 3'b000, "three");
        run_op(32'h3F000000, 32'h40000000, 0, 9, 3'b000, "half");
        run_op(32'h40A00000, 32'h3E4CCCCD, 2, 9, 3'b000, "five");
        run_op(32'h00000000, 32'h7F800000, 0, 2, 3'b001, "zero");
        run_op(32'h80000001, 32'hFF800000, 0, 2, 3'b001, "neg_subnormal");
        run_op(32'hFF800000, 32'h80000000, 0, 2, 3'b000, "neg_inf");
        run_op(32'h7FC12345, 32'h7FC00000, 0, 2, 3'b010, "nan");
        run_op(32'h7F000000, 32'h00000000, 0, 9, 3'b100, "uflow_pow2");
        run_op(32'hFF400000, 32'h80000000, 0, 9, 3'b100, "uflow_neg");

        // Backpressure: hold out_ready low in DONE, poke in_valid meanwhile
        out_ready = 1'b0;
        X         = 32'h40800000;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        guard    = 0;
        while (!out_valid && guard < 60) begin
            step();
            guard++;
        end
        chk("bp_y_first", Y, 32'h3E800000);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                X        = 32'h3F800000;
                in_valid = 1'b1;
            end
            step();
            chk("bp_hold", {30'd0, out_valid, in_ready}, 32'h2);
            chk("bp_y_stable", Y, 32'h3E800000);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release", {30'd0, out_valid, in_ready}, 32'h1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) seen++;
        end
        chk("bp_no_ghost", 32'(seen), 32'h0);

        // Reset during MUL_A aborts the operation
        X        = 32'h40000000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'h0);
        chk("abort_in_ready", 32'(in_ready), 32'h1);
        chk("abort_y", Y, 32'h0);
        #2;
        rst_n = 1'b1;
        step();
        run_op(32'h40000000, 32'h3F000000, 0, 9, 3'b000, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
